// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction-fetch stage.
//   fetch_state_t : fetch FSM states
//   if_id_t       : IF/ID pipeline register payload
package fetch_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned COUNT_W = 32;

  localparam logic [ADDR_W-1:0]  END_ADDR_DEF  = ADDR_W'(161);
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = '0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle around the fetch stage: PC register, instruction memory,
// hazard/branch controls and the IF/ID outputs.
//   master : the fetch stage itself
//   slave  : everything around it (PC register, imem, hazard unit, decode)
interface fetch_stage_if
  import fetch_pkg::*;
();

  logic [ADDR_W-1:0]  pc_cur;
  logic [ADDR_W-1:0]  pc_next;
  logic               pc_load;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               flush;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_target;
  logic               if_id_valid;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0]  if_id_pc;
  logic               halted;
  logic [COUNT_W-1:0] fetch_count;

  modport master (
    input  pc_cur, imem_rdata, stall, flush, br_taken, br_target,
    output pc_next, pc_load, imem_addr, if_id_valid, if_id_instr, if_id_pc,
           halted, fetch_count
  );

  modport slave (
    output pc_cur, imem_rdata, stall, flush, br_taken, br_target,
    input  pc_next, pc_load, imem_addr, if_id_valid, if_id_instr, if_id_pc,
           halted, fetch_count
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst : clock, async active-low reset (resets to an invalid NOP)
//   load     : capture d
//   clear    : force an invalid NOP (wins over load)
//   d, q     : payload in / registered payload out
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clear,
  input  if_id_t d,
  output if_id_t q
);

  localparam if_id_t EMPTY = '{valid: 1'b0, instr: NOP_INSTR, pc: '0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        q <= EMPTY;
    else if (clear)  q <= EMPTY;
    else if (load)   q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: next-PC selection, imem addressing, IF/ID capture,
// stall/flush/branch handling and halt at END_ADDR.
//   clk, rst : clock, async active-low reset
//   bus      : fetch_stage_if master (PC register, imem, controls, IF/ID out)
// pc_next, pc_load and imem_addr are combinational; all else is registered.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  END_ADDR  = END_ADDR_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  fetch_state_t       state, state_n;
  logic               req_valid, req_valid_n;
  logic [ADDR_W-1:0]  req_pc, req_pc_n;
  logic [COUNT_W-1:0] count, count_n;
  logic               halted, halted_n;
  logic [ADDR_W-1:0]  pc_next_c;
  logic               pc_load_c;
  logic               ifid_load, ifid_clear;
  logic               hold_addr;
  if_id_t             ifid_d, ifid_q;

  // State register and request tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      req_valid <= 1'b0;
      req_pc    <= '0;
      count     <= '0;
      halted    <= 1'b0;
    end else begin
      state     <= state_n;
      req_valid <= req_valid_n;
      req_pc    <= req_pc_n;
      count     <= count_n;
      halted    <= halted_n;
    end
  end

  // Priority: br_taken > flush > stall > halt > normal.
  // A flush kills the returning word but still issues pc_cur, so the
  // instruction after the flushed one is fetched without a PC rewind.
  always_comb begin
    state_n     = state;
    req_valid_n = req_valid;
    req_pc_n    = req_pc;
    count_n     = count;
    pc_next_c   = bus.pc_cur + ADDR_W'(1);
    pc_load_c   = 1'b0;
    ifid_load   = 1'b0;
    ifid_clear  = 1'b0;

    if (bus.br_taken) begin
      pc_next_c   = bus.br_target;
      pc_load_c   = 1'b1;
      req_valid_n = 1'b0;
      ifid_clear  = 1'b1;
      state_n     = RUN;
    end else if (bus.flush || !bus.stall) begin
      if (bus.flush) begin
        ifid_clear = 1'b1;
      end else begin
        ifid_load = 1'b1;
        count_n   = count + COUNT_W'(req_valid);
      end
      if (state == HALT) begin
        req_valid_n = 1'b0;
      end else begin
        req_valid_n = 1'b1;
        req_pc_n    = bus.pc_cur;
        if (bus.pc_cur == END_ADDR) state_n   = HALT;
        else                        pc_load_c = 1'b1;
      end
    end

    halted_n = (state_n == HALT) && !req_valid_n;
  end

  // Replay the outstanding address only on a true hold so imem_rdata stays
  // stable; flush/branch cycles are not holds.
  assign hold_addr = bus.stall && !bus.flush && !bus.br_taken && req_valid;

  assign ifid_d = '{valid: req_valid,
                    instr: req_valid ? bus.imem_rdata : NOP_INSTR,
                    pc:    req_pc};

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .load  (ifid_load),
    .clear (ifid_clear),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign bus.imem_addr   = hold_addr ? req_pc : bus.pc_cur;
  assign bus.pc_next     = pc_next_c;
  assign bus.pc_load     = rst && pc_load_c;
  assign bus.if_id_valid = ifid_q.valid;
  assign bus.if_id_instr = ifid_q.instr;
  assign bus.if_id_pc    = ifid_q.pc;
  assign bus.halted      = halted;
  assign bus.fetch_count = count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a PC register and a synchronous
// instruction memory returning 0x100 + address.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // PC register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             bus.pc_cur <= '0;
    else if (bus.pc_load) bus.pc_cur <= bus.pc_next;
  end

  // Synchronous instruction memory, 1-cycle read latency
  always_ff @(posedge clk) bus.imem_rdata <= 32'h100 + bus.imem_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr, input logic [31:0] cnt);
    chk({tag, ".valid"}, 32'(bus.if_id_valid), 32'(v));
    chk({tag, ".pc"},    bus.if_id_pc,    pc);
    chk({tag, ".instr"}, bus.if_id_instr, instr);
    chk({tag, ".count"}, bus.fetch_count, cnt);
  endtask

  initial begin
    rst           = 1'b0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = '0;
    repeat (2) tick();

    // Reset state
    chk_ifid("reset", 1'b0, 32'd0, 32'd0, 32'd0);
    chk("reset.halted",  32'(bus.halted),  32'd0);
    chk("reset.pc_load", 32'(bus.pc_load), 32'd0);

    // Sequential fetch
    #3 rst = 1'b1;
    #1;
    chk("seq.pc_load",   32'(bus.pc_load), 32'd1);
    chk("seq.pc_next",   bus.pc_next,      32'd1);
    chk("seq.imem_addr", bus.imem_addr,    32'd0);
    tick();
    chk("seq.first_invalid", 32'(bus.if_id_valid), 32'd0);
    tick(); chk_ifid("seq0", 1'b1, 32'd0, 32'h100, 32'd1);
    tick(); chk_ifid("seq1", 1'b1, 32'd1, 32'h101, 32'd2);
    tick(); chk_ifid("seq2", 1'b1, 32'd2, 32'h102, 32'd3);
    tick(); chk_ifid("seq3", 1'b1, 32'd3, 32'h103, 32'd4);

    // Stall with pc_cur=5, req_pc=4
    chk("stall.pc_cur", bus.pc_cur, 32'd5);
    bus.stall = 1'b1;
    #1;
    chk("stall.imem_addr", bus.imem_addr,    32'd4);
    chk("stall.pc_load",   32'(bus.pc_load), 32'd0);
    tick(); chk_ifid("stall1", 1'b1, 32'd3, 32'h103, 32'd4);
    tick(); chk_ifid("stall2", 1'b1, 32'd3, 32'h103, 32'd4);
    chk("stall.pc_hold", bus.pc_cur, 32'd5);
    bus.stall = 1'b0;
    tick(); chk_ifid("stall.rel4", 1'b1, 32'd4, 32'h104, 32'd5);
    tick(); chk_ifid("stall.rel5", 1'b1, 32'd5, 32'h105, 32'd6);
    tick(); chk_ifid("seq6",       1'b1, 32'd6, 32'h106, 32'd7);

    // Branch under stall with req_pc=7
    bus.stall     = 1'b1;
    bus.br_taken  = 1'b1;
    bus.br_target = 32'd40;
    #1;
    chk("br.pc_next", bus.pc_next,      32'd40);
    chk("br.pc_load", 32'(bus.pc_load), 32'd1);
    tick();
    bus.stall    = 1'b0;
    bus.br_taken = 1'b0;
    chk_ifid("br.kill", 1'b0, 32'd0, 32'd0, 32'd7);
    chk("br.pc_cur", bus.pc_cur, 32'd40);
    tick(); chk("br.bubble", 32'(bus.if_id_valid), 32'd0);
    tick(); chk_ifid("br.tgt40", 1'b1, 32'd40, 32'h128, 32'd8);
    tick(); chk_ifid("br.tgt41", 1'b1, 32'd41, 32'h129, 32'd9);

    // Flush one cycle at req_pc=42
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk_ifid("flush", 1'b0, 32'd0, 32'd0, 32'd9);
    tick(); chk_ifid("flush.next43", 1'b1, 32'd43, 32'h12b, 32'd10);

    // Run to END_ADDR via a branch to 159
    bus.br_taken  = 1'b1;
    bus.br_target = 32'd159;
    tick();
    bus.br_taken = 1'b0;
    tick();
    tick(); chk_ifid("end.159", 1'b1, 32'd159, 32'h19f, 32'd11);
    chk("end.pc_cur",  bus.pc_cur,       32'd161);
    chk("end.pc_load", 32'(bus.pc_load), 32'd0);
    tick(); chk_ifid("end.160", 1'b1, 32'd160, 32'h1a0, 32'd12);
    chk("end.halted0", 32'(bus.halted),  32'd0);
    chk("end.pc_load2", 32'(bus.pc_load), 32'd0);
    tick(); chk_ifid("end.161", 1'b1, 32'd161, 32'h1a1, 32'd13);
    chk("end.halted1", 32'(bus.halted), 32'd1);
    tick();
    chk("halt.drained", 32'(bus.if_id_valid), 32'd0);
    chk("halt.count",   bus.fetch_count,      32'd13);
    chk("halt.halted",  32'(bus.halted),      32'd1);
    chk("halt.pc_load", 32'(bus.pc_load),     32'd0);
    chk("halt.pc_cur",  bus.pc_cur,           32'd161);

    // Branch out of HALT to 0
    bus.br_taken  = 1'b1;
    bus.br_target = 32'd0;
    #1;
    chk("halt.br.pc_next", bus.pc_next,      32'd0);
    chk("halt.br.pc_load", 32'(bus.pc_load), 32'd1);
    tick();
    bus.br_taken = 1'b0;
    chk("halt.br.halted", 32'(bus.halted), 32'd0);
    tick();
    tick(); chk_ifid("halt.br.pc0", 1'b1, 32'd0, 32'h100, 32'd14);

    // Asynchronous reset mid-run
    #3 rst = 1'b0;
    #1;
    chk_ifid("arst", 1'b0, 32'd0, 32'd0, 32'd0);
    chk("arst.halted",  32'(bus.halted),  32'd0);
    chk("arst.pc_load", 32'(bus.pc_load), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("arst.rel_invalid", 32'(bus.if_id_valid), 32'd0);
    tick(); chk_ifid("arst.pc0", 1'b1, 32'd0, 32'h100, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
